traffic_conflict_monitor: RTL
=============================

# traffic_conflict_monitor

Safety stage between `traffic_light_controller` and the lamp drivers. It takes the controller's six lamp signals and checks them every cycle for conflicting greens, malformed heads, illegal colour sequences and short yellows. Legal lamp states pass through with one register stage. On any violation the block latches a fault code and drives both directions to flashing red until a qualified clear.

## Interface
Parameters:
- `CLOCK_FREQ_HZ`, 50_000_000, clock frequency in Hz.
- `MIN_YELLOW_S`, 1, minimum legal yellow time in seconds. `MIN_YELLOW_CYCLES = CLOCK_FREQ_HZ*MIN_YELLOW_S`.
- `FLASH_HALF_CYCLES`, 25_000_000, on-time and off-time of the failsafe red flash, in cycles.

Ports:
- `clk` in 1, sole clock, rising edge.
- `rst` in 1, asynchronous, active-high reset.
- `ns_red_in`, `ns_yellow_in`, `ns_green_in` in 1 each, north-south lamps from the controller.
- `ew_red_in`, `ew_yellow_in`, `ew_green_in` in 1 each, east-west lamps from the controller.
- `fault_clear` in 1, request to leave the fault state.
- `ns_red`, `ns_yellow`, `ns_green` out 1 each, north-south lamp drive.
- `ew_red`, `ew_yellow`, `ew_green` out 1 each, east-west lamp drive.
- `fault` out 1, high while in the FAULT state.
- `fault_code` out 3, cause of the latched fault. 0 means no fault.

## Operation
- Two states: MONITOR and FAULT. Reset enters MONITOR.
- Per direction, the block keeps a previous-lamp register (reset value: red) and a yellow counter.
  - The yellow counter increments while the direction's yellow input is high and saturates at `MIN_YELLOW_CYCLES`.
  - It clears to 0 whenever that yellow input is low.
  - Width is `$clog2(MIN_YELLOW_CYCLES+1)`.
- In MONITOR, every edge checks the current inputs against the previous-lamp registers:
  - code 1, conflict: (ns_green|ns_yellow) & (ew_green|ew_yellow).
  - code 2, malformed head: either direction does not have exactly one lamp lit (none lit, or more than one).
  - code 3, illegal sequence: a direction changes colour by any transition other than red→green, green→yellow or yellow→red.
  - code 4, short yellow: yellow→red while that direction's yellow counter is below `MIN_YELLOW_CYCLES`.
  - If several checks fire on the same edge, the lowest code is latched.
- MONITOR with no violation: the outputs register the inputs and the previous-lamp registers update.
- MONITOR with a violation:
  - Enter FAULT and set `fault=1`.
  - Latch `fault_code`.
  - Force all yellow and green outputs to 0.
  - The bad input pattern never reaches the outputs.
- FAULT:
  - `ns_red` and `ew_red` flash together, high for `FLASH_HALF_CYCLES` edges, then low for `FLASH_HALF_CYCLES` edges, repeating.
  - Yellow and green outputs stay 0.
  - Inputs are not checked and `fault_code` holds.
- Clearing a fault: `fault_clear=1` in FAULT, with inputs exactly ns_red_in=1 and ew_red_in=1 and all other inputs 0, causes on that edge:
  - Return to MONITOR.
  - `fault=0` and `fault_code=0`.
  - Outputs show red/red and the previous-lamp registers load red.
  - Yellow counters clear.
  - No sequence check runs on this edge.
- `fault_clear` with any other input pattern is ignored. `fault_clear` in MONITOR is ignored.

## Timing
- Reset values:
  - ns_red=1, ew_red=1, all yellow and green outputs 0.
  - fault=0, fault_code=0.
  - State MONITOR.
  - Flash counter 0, flash phase "on".
  - Yellow counters 0.
  - Previous-lamp registers red.
- Reset acts immediately, without waiting for a clock edge, including in the middle of a flash.
- Pass-through latency: one clock. Inputs sampled at edge k appear on the outputs after edge k.
- Fault latency: a violation present at edge k sets fault, fault_code and red=1 after edge k.
- Flash counter:
  - It counts 0..FLASH_HALF_CYCLES-1, then toggles the phase and wraps to 0.
  - It restarts at 0 with phase "on" on every entry to FAULT.
- Yellow minimum: yellow held for exactly `MIN_YELLOW_CYCLES` sampled edges is legal. One edge fewer is a code 4 fault.
- Priority: a violation and `fault_clear` on the same MONITOR edge resolve as fault. Reset overrides everything.

## Test plan
Bench parameters: CLOCK_FREQ_HZ=10, MIN_YELLOW_S=1 (10 cycles), FLASH_HALF_CYCLES=3.
- Reset, then a legal cycle: NS green 20 cycles → yellow 10 → red with EW red, then EW green. Outputs must mirror inputs one cycle later, with fault=0 throughout.
- ns_green_in=1 and ew_green_in=1 on the same edge. After that edge: fault=1, fault_code=1, red/red. Reds must stay high for 3 edges, low for 3 edges, then repeat.
- NS yellow for 9 cycles then red: fault_code=4. Repeat with 10 cycles: no fault.
- NS green→red directly: fault_code=3. Separately, all NS inputs 0: fault_code=2.
- In FAULT, `fault_clear=1` with ns_green_in=1: no change. Then `fault_clear=1` with red/red inputs: after the next edge fault=0, fault_code=0, outputs red/red.
- Assert rst mid-flash while reds are low: ns_red and ew_red go to 1 immediately, fault=0, and stay static until normal pass-through resumes.

Source files
------------

// File: rtl/traffic_conflict_monitor.sv
// Safety stage between the traffic light controller and the lamp drivers: passes legal
// lamp states through one register, latches a fault code and flashes red/red on violations.
module traffic_conflict_monitor #(
  parameter int unsigned CLOCK_FREQ_HZ     = 50_000_000,
  parameter int unsigned MIN_YELLOW_S      = 1,
  parameter int unsigned FLASH_HALF_CYCLES = 25_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ns_red_in,
  input  logic       ns_yellow_in,
  input  logic       ns_green_in,
  input  logic       ew_red_in,
  input  logic       ew_yellow_in,
  input  logic       ew_green_in,
  input  logic       fault_clear,
  output logic       ns_red,
  output logic       ns_yellow,
  output logic       ns_green,
  output logic       ew_red,
  output logic       ew_yellow,
  output logic       ew_green,
  output logic       fault,
  output logic [2:0] fault_code
);

  localparam int unsigned MIN_YELLOW_CYCLES = CLOCK_FREQ_HZ * MIN_YELLOW_S;
  localparam int unsigned YW = $clog2(MIN_YELLOW_CYCLES + 1);
  localparam int unsigned FW = (FLASH_HALF_CYCLES > 1) ? $clog2(FLASH_HALF_CYCLES) : 1;

  localparam logic [YW-1:0] MinYellow = YW'(MIN_YELLOW_CYCLES);
  localparam logic [FW-1:0] FlashLast = FW'(FLASH_HALF_CYCLES - 1);

  // Lamp vectors are {red, yellow, green}.
  localparam logic [2:0] LampRed    = 3'b100;
  localparam logic [2:0] LampYellow = 3'b010;
  localparam logic [2:0] LampGreen  = 3'b001;
  localparam logic [2:0] LampOff    = 3'b000;

  typedef enum logic {StMonitor, StFault} state_e;

  state_e          state_q, state_d;
  logic [2:0]      ns_prev_q, ns_prev_d, ew_prev_q, ew_prev_d;
  logic [2:0]      ns_out_q, ns_out_d, ew_out_q, ew_out_d;
  logic [YW-1:0]   ns_ycnt_q, ns_ycnt_d, ew_ycnt_q, ew_ycnt_d;
  logic [FW-1:0]   flash_cnt_q, flash_cnt_d;
  logic            flash_on_q, flash_on_d;
  logic [2:0]      code_q, code_d;

  logic [2:0]      ns_in, ew_in;
  logic            conflict, malformed, bad_seq, short_yellow, clear_ok;
  logic [2:0]      viol_code;

  assign ns_in = {ns_red_in, ns_yellow_in, ns_green_in};
  assign ew_in = {ew_red_in, ew_yellow_in, ew_green_in};

  function automatic logic one_lamp(input logic [2:0] l);
    return (l == LampRed) || (l == LampYellow) || (l == LampGreen);
  endfunction

  function automatic logic legal_step(input logic [2:0] prev, input logic [2:0] cur);
    return (cur == prev) ||
           ((prev == LampRed)    && (cur == LampGreen))  ||
           ((prev == LampGreen)  && (cur == LampYellow)) ||
           ((prev == LampYellow) && (cur == LampRed));
  endfunction

  function automatic logic yellow_short(input logic [2:0] prev, input logic [2:0] cur,
                                        input logic [YW-1:0] cnt);
    return (prev == LampYellow) && (cur == LampRed) && (cnt < MinYellow);
  endfunction

  always_comb begin
    conflict     = (ns_yellow_in | ns_green_in) & (ew_yellow_in | ew_green_in);
    malformed    = !one_lamp(ns_in) || !one_lamp(ew_in);
    bad_seq      = !legal_step(ns_prev_q, ns_in) || !legal_step(ew_prev_q, ew_in);
    short_yellow = yellow_short(ns_prev_q, ns_in, ns_ycnt_q) ||
                   yellow_short(ew_prev_q, ew_in, ew_ycnt_q);
    clear_ok     = fault_clear && (ns_in == LampRed) && (ew_in == LampRed);
    viol_code = 3'd0;
    if (conflict)          viol_code = 3'd1;
    else if (malformed)    viol_code = 3'd2;
    else if (bad_seq)      viol_code = 3'd3;
    else if (short_yellow) viol_code = 3'd4;
  end

  always_comb begin
    state_d     = state_q;
    ns_prev_d   = ns_prev_q;
    ew_prev_d   = ew_prev_q;
    ns_out_d    = ns_out_q;
    ew_out_d    = ew_out_q;
    flash_cnt_d = flash_cnt_q;
    flash_on_d  = flash_on_q;
    code_d      = code_q;
    // Yellow run length, saturating; zero whenever the yellow lamp is off.
    ns_ycnt_d = ns_yellow_in ? ((ns_ycnt_q == MinYellow) ? ns_ycnt_q : ns_ycnt_q + 1'b1) : '0;
    ew_ycnt_d = ew_yellow_in ? ((ew_ycnt_q == MinYellow) ? ew_ycnt_q : ew_ycnt_q + 1'b1) : '0;

    unique case (state_q)
      StMonitor: begin
        if (viol_code != 3'd0) begin
          state_d     = StFault;
          code_d      = viol_code;
          ns_out_d    = LampRed;
          ew_out_d    = LampRed;
          flash_cnt_d = '0;
          flash_on_d  = 1'b1;
        end else begin
          ns_out_d  = ns_in;
          ew_out_d  = ew_in;
          ns_prev_d = ns_in;
          ew_prev_d = ew_in;
        end
      end
      StFault: begin
        if (clear_ok) begin
          state_d   = StMonitor;
          code_d    = 3'd0;
          ns_out_d  = LampRed;
          ew_out_d  = LampRed;
          ns_prev_d = LampRed;
          ew_prev_d = LampRed;
          ns_ycnt_d = '0;
          ew_ycnt_d = '0;
        end else begin
          if (flash_cnt_q == FlashLast) begin
            flash_cnt_d = '0;
            flash_on_d  = ~flash_on_q;
          end else begin
            flash_cnt_d = flash_cnt_q + 1'b1;
          end
          ns_out_d = flash_on_d ? LampRed : LampOff;
          ew_out_d = flash_on_d ? LampRed : LampOff;
        end
      end
      default: state_d = StMonitor;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StMonitor;
      ns_prev_q   <= LampRed;
      ew_prev_q   <= LampRed;
      ns_out_q    <= LampRed;
      ew_out_q    <= LampRed;
      ns_ycnt_q   <= '0;
      ew_ycnt_q   <= '0;
      flash_cnt_q <= '0;
      flash_on_q  <= 1'b1;
      code_q      <= 3'd0;
    end else begin
      state_q     <= state_d;
      ns_prev_q   <= ns_prev_d;
      ew_prev_q   <= ew_prev_d;
      ns_out_q    <= ns_out_d;
      ew_out_q    <= ew_out_d;
      ns_ycnt_q   <= ns_ycnt_d;
      ew_ycnt_q   <= ew_ycnt_d;
      flash_cnt_q <= flash_cnt_d;
      flash_on_q  <= flash_on_d;
      code_q      <= code_d;
    end
  end

  assign {ns_red, ns_yellow, ns_green} = ns_out_q;
  assign {ew_red, ew_yellow, ew_green} = ew_out_q;
  assign fault      = (state_q == StFault);
  assign fault_code = code_q;

endmodule
